canny_frame_sequencer: RTL and testbench

Frame-level controller for the Canny processing core inside the VIP flow-control wrapper. It latches the incoming control packet, forwards output dimensions and requests the outgoing control packet. It then gates pixel reads for exactly width*height beats and holds off end-of-video until the core has emitted the same number of output beats. This replaces ad-hoc empty-FIFO end-of-video detection with deterministic pixel accounting and a drain watchdog.

---
 rtl/canny_pkg.sv | 15 +
 rtl/canny_beat_counter.sv | 23 ++
 rtl/canny_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_canny_frame_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny frame sequencer: FSM encoding and default limits.
package canny_pkg;
  localparam int MAX_WIDTH_DEF  = 1920;
  localparam int MAX_HEIGHT_DEF = 1080;
  localparam int CNT_W_DEF      = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_CTRL,
    S_STREAM,
    S_DRAIN,
    S_EOV
  } state_t;
endpackage

// File: rtl/canny_beat_counter.sv
// Saturating beat counter with synchronous clear and an equality-to-limit flag.
module canny_beat_counter
  import canny_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit
);
  assign at_limit = (cnt == limit);

  // Beats arriving once the limit is reached are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !at_limit)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame controller: latches the control packet, gates input reads to width*height
// beats and releases end-of-video once the same number of output beats drained.
module canny_frame_sequencer
  import canny_pkg::*;
#(
  parameter int MAX_WIDTH     = MAX_WIDTH_DEF,
  parameter int MAX_HEIGHT    = MAX_HEIGHT_DEF,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vip_ctrl_valid,
  input  logic [15:0] width_in,
  input  logic [15:0] height_in,
  input  logic [3:0]  interlaced_in,
  input  logic        vip_ctrl_busy,
  output logic        vip_ctrl_send,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [3:0]  interlaced_out,
  input  logic        in_beat,
  input  logic        out_beat,
  output logic        in_enable,
  output logic        end_of_video_out,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        err_dims,
  output logic        err_timeout
);
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   total, in_cnt, out_cnt;
  logic               in_done, out_done, in_last, cnt_clr;
  logic               dims_ok, ctrl_accept;
  logic [IDLE_W-1:0]  idle_cnt;

  assign dims_ok = (width_in != 16'd0) && (height_in != 16'd0) &&
                   (width_in <= 16'(MAX_WIDTH)) && (height_in <= 16'(MAX_HEIGHT));

  // Final input beat seen this cycle: leave STREAM without waiting for the count.
  assign in_last = in_beat && (in_cnt == total - CNT_W'(1));
  assign cnt_clr = (state == S_EOV);

  canny_beat_counter #(.W(CNT_W)) u_in_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (in_beat && (state == S_STREAM)),
    .limit    (total),
    .cnt      (in_cnt),
    .at_limit (in_done)
  );

  canny_beat_counter #(.W(CNT_W)) u_out_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (out_beat && (state != S_IDLE)),
    .limit    (total),
    .cnt      (out_cnt),
    .at_limit (out_done)
  );

  always_comb begin
    state_nxt     = state;
    vip_ctrl_send = 1'b0;
    err_dims      = 1'b0;
    err_timeout   = 1'b0;
    ctrl_accept   = 1'b0;
    case (state)
      S_IDLE: if (vip_ctrl_valid) begin
        if (dims_ok) begin
          ctrl_accept = 1'b1;
          state_nxt   = S_CALC;
        end else begin
          err_dims = 1'b1;
        end
      end
      S_CALC:   state_nxt = S_CTRL;
      S_CTRL: if (!vip_ctrl_busy) begin
        vip_ctrl_send = 1'b1;
        state_nxt     = S_STREAM;
      end
      S_STREAM: if (in_done || in_last) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (out_done) begin
          state_nxt = S_EOV;
        end else if (idle_cnt == IDLE_LAST) begin
          err_timeout = 1'b1;
          state_nxt   = S_EOV;
        end
      end
      S_EOV:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      total          <= '0;
      width_out      <= 16'(MAX_WIDTH);
      height_out     <= 16'(MAX_HEIGHT);
      interlaced_out <= 4'd0;
      idle_cnt       <= '0;
      frame_count    <= 16'd0;
    end else begin
      state <= state_nxt;
      if (ctrl_accept) begin
        width_out      <= width_in;
        height_out     <= height_in;
        interlaced_out <= interlaced_in;
      end
      if (state == S_CALC)
        total <= CNT_W'(width_out) * CNT_W'(height_out);
      if (state == S_DRAIN) idle_cnt <= out_beat ? '0 : idle_cnt + IDLE_W'(1);
      else                  idle_cnt <= '0;
      if (state == S_EOV) frame_count <= frame_count + 16'd1;
    end
  end

  assign in_enable        = (state == S_STREAM) && !in_done;
  assign end_of_video_out = (state == S_EOV);
  assign busy             = (state != S_IDLE);
endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Directed bench for canny_frame_sequencer: vector table plus multi-cycle corner sequences.
module tb_canny_frame_sequencer;
  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vip_ctrl_valid, vip_ctrl_busy, in_beat, out_beat;
  logic [15:0] width_in, height_in;
  logic [3:0]  interlaced_in;
  logic        vip_ctrl_send, in_enable, end_of_video_out, busy, err_dims, err_timeout;
  logic [15:0] width_out, height_out, frame_count;
  logic [3:0]  interlaced_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  canny_frame_sequencer #(.DRAIN_TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vip_ctrl_valid   (vip_ctrl_valid),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .vip_ctrl_busy    (vip_ctrl_busy),
    .vip_ctrl_send    (vip_ctrl_send),
    .width_out        (width_out),
    .height_out       (height_out),
    .interlaced_out   (interlaced_out),
    .in_beat          (in_beat),
    .out_beat         (out_beat),
    .in_enable        (in_enable),
    .end_of_video_out (end_of_video_out),
    .busy             (busy),
    .frame_count      (frame_count),
    .err_dims         (err_dims),
    .err_timeout      (err_timeout)
  );

  // flags = {send, in_enable, eov, busy, err_dims, err_timeout}
  typedef struct {
    logic        vld;
    logic [15:0] w, h;
    logic [3:0]  il;
    logic        cbusy, inb, outb;
    logic [5:0]  flags;
    logic [15:0] wo, ho;
    logic [3:0]  ilo;
    logic [15:0] fc;
  } vec_t;

  function automatic vec_t v(input logic vld, input logic [15:0] w, h, input logic [3:0] il,
                             input logic cbusy, inb, outb, input logic [5:0] flags,
                             input logic [15:0] wo, ho, input logic [3:0] ilo, input logic [15:0] fc);
    vec_t r;
    r.vld = vld; r.w = w; r.h = h; r.il = il; r.cbusy = cbusy; r.inb = inb; r.outb = outb;
    r.flags = flags; r.wo = wo; r.ho = ho; r.ilo = ilo; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'h0, vip_ctrl_send, in_enable, end_of_video_out, busy, err_dims, err_timeout,
            width_out, height_out, interlaced_out, frame_count};
  endfunction

  task automatic start_frame(input logic [15:0] w, h);
    @(negedge clk); vip_ctrl_valid = 1'b1; width_in = w; height_in = h;
    @(negedge clk); vip_ctrl_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic beats(input int n_in, input int n_out);
    int n;
    n = (n_in > n_out) ? n_in : n_out;
    for (int i = 0; i < n; i++) begin
      in_beat  = (i < n_in);
      out_beat = (i < n_out);
      @(negedge clk);
    end
    in_beat  = 1'b0;
    out_beat = 1'b0;
  endtask

  task automatic wait_eov(output int n);
    n = 0;
    #1;
    while (!end_of_video_out && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  vec_t tbl[18];
  int   n;

  initial begin
    rst_n = 1'b0; vip_ctrl_valid = 1'b0; vip_ctrl_busy = 1'b0; in_beat = 1'b0; out_beat = 1'b0;
    width_in = 16'd0; height_in = 16'd0; interlaced_in = 4'd0;

    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 6'b000000, 1920, 1080, 0, 0);
    tbl[1]  = v(1, 0, 1080, 0, 0, 0, 0, 6'b000010, 1920, 1080, 0, 0);
    tbl[2]  = v(1, 2000, 10, 0, 0, 0, 0, 6'b000010, 1920, 1080, 0, 0);
    tbl[3]  = v(1, 1920, 1081, 0, 0, 0, 0, 6'b000010, 1920, 1080, 0, 0);
    tbl[4]  = v(1, 4, 2, 3, 0, 0, 0, 6'b000000, 1920, 1080, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 6'b000100, 4, 2, 3, 0);
    tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 6'b100100, 4, 2, 3, 0);
    for (int i = 7; i < 15; i++)
      tbl[i] = v(0, 0, 0, 0, 0, 1, 1, 6'b010100, 4, 2, 3, 0);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 6'b000100, 4, 2, 3, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 6'b001100, 4, 2, 3, 0);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 6'b000000, 4, 2, 3, 1);

    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", outs(), {6'h0, 6'b000000, 16'd1920, 16'd1080, 4'd0, 16'd0});
    @(negedge clk); rst_n = 1'b1;

    // 4x2 frame with dimension rejects up front
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      vip_ctrl_valid = tbl[i].vld; width_in = tbl[i].w; height_in = tbl[i].h;
      interlaced_in = tbl[i].il; vip_ctrl_busy = tbl[i].cbusy;
      in_beat = tbl[i].inb; out_beat = tbl[i].outb;
      #1 chk($sformatf("vec%0d", i), outs(),
             {6'h0, tbl[i].flags, tbl[i].wo, tbl[i].ho, tbl[i].ilo, tbl[i].fc});
    end

    // encoder busy for 5 cycles in CTRL
    @(negedge clk); vip_ctrl_valid = 1'b1; width_in = 16'd3; height_in = 16'd1; vip_ctrl_busy = 1'b1;
    @(negedge clk); vip_ctrl_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1 chk("send_held_busy", {63'h0, vip_ctrl_send}, 64'd0);
    end
    @(negedge clk); vip_ctrl_busy = 1'b0;
    #1 chk("send_on_release", {63'h0, vip_ctrl_send}, 64'd1);
    @(negedge clk); #1 chk("send_single_then_stream", {62'h0, vip_ctrl_send, in_enable}, 64'b01);
    beats(3, 3);
    wait_eov(n); chk("busy_frame_eov_latency", n, 1);
    @(negedge clk); #1 chk("busy_frame_count", frame_count, 2);

    // 2x2 frame, output stalls after 3 beats: watchdog closes it
    start_frame(16'd2, 16'd2);
    beats(4, 3);
    n = 1;
    #1;
    while (!err_timeout && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_no_eov_yet", {63'h0, end_of_video_out}, 64'd0);
    @(negedge clk); #1 chk("timeout_eov", {62'h0, end_of_video_out, err_timeout}, 64'b10);
    @(negedge clk); #1 chk("timeout_frame_count", frame_count, 3);

    // 4x4 frame with a stray 8x8 control packet mid-stream
    start_frame(16'd4, 16'd4);
    beats(5, 5);
    vip_ctrl_valid = 1'b1; width_in = 16'd8; height_in = 16'd8;
    #1 chk("stray_ctrl_no_err", {63'h0, err_dims}, 64'd0);
    @(negedge clk); vip_ctrl_valid = 1'b0;
    #1 chk("stray_ctrl_width", width_out, 4);
    beats(10, 10);
    #1 chk("stray_one_beat_left", {63'h0, in_enable}, 64'd1);
    beats(1, 1);
    #1 chk("stray_drain_in_enable", {62'h0, in_enable, end_of_video_out}, 64'b00);
    wait_eov(n); chk("stray_eov_latency", n, 1);
    @(negedge clk); #1 chk("stray_frame_count", frame_count, 4);

    // minimum 1x1 frame: EOV two cycles after the output beat
    start_frame(16'd1, 16'd1);
    beats(1, 1);
    wait_eov(n); chk("min_frame_eov_latency", n, 1);
    @(negedge clk); #1 chk("min_frame_count", frame_count, 5);

    // reset mid-STREAM, then a clean 2x2 frame
    start_frame(16'd2, 16'd2);
    beats(2, 2);
    rst_n = 1'b0;
    #1 chk("midframe_reset", outs(), {6'h0, 6'b000000, 16'd1920, 16'd1080, 4'd0, 16'd0});
    @(negedge clk); rst_n = 1'b1;
    start_frame(16'd2, 16'd2);
    beats(4, 4);
    wait_eov(n); chk("post_reset_eov_latency", n, 1);
    @(negedge clk); #1 chk("post_reset_frame_count", {frame_count, width_out}, {16'd1, 16'd2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
